// File: rtl/wallace_accum_ctrl.sv
// wallace_accum_ctrl: sums a framed operand stream by batching up to 17
// operands per pass into one shared 18-input Wallace adder. The running
// accumulator occupies the 18th adder input. One sum is emitted per frame.

// Wallace_adder_18: 18-operand adder, modulo 2^W.
// Carry-save 3:2 compression reduces 18 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
// One carry-propagate add then produces the result.
// Every carry row is shifted left and truncated, so all arithmetic wraps at W bits.
module Wallace_adder_18 #(
    parameter int W = 16
) (
    input  logic [18*W-1:0] ops_flat,
    output logic [W-1:0]    sum
);
    logic [W-1:0] l0 [18];
    logic [W-1:0] l1 [12];
    logic [W-1:0] l2 [8];
    logic [W-1:0] l3 [6];
    logic [W-1:0] l4 [4];
    logic [W-1:0] l5 [3];
    logic [W-1:0] l6 [2];

    generate
        for (genvar gi = 0; gi < 18; gi++) begin : g_unpack
            assign l0[gi] = ops_flat[gi*W +: W];
        end

        // 18 -> 12: six full-adder rows
        for (genvar gi = 0; gi < 6; gi++) begin : g_lvl1
            assign l1[2*gi]   = l0[3*gi] ^ l0[3*gi+1] ^ l0[3*gi+2];
            assign l1[2*gi+1] = ((l0[3*gi] & l0[3*gi+1]) | (l0[3*gi] & l0[3*gi+2])
                               | (l0[3*gi+1] & l0[3*gi+2])) << 1;
        end

        // 12 -> 8
        for (genvar gi = 0; gi < 4; gi++) begin : g_lvl2
            assign l2[2*gi]   = l1[3*gi] ^ l1[3*gi+1] ^ l1[3*gi+2];
            assign l2[2*gi+1] = ((l1[3*gi] & l1[3*gi+1]) | (l1[3*gi] & l1[3*gi+2])
                               | (l1[3*gi+1] & l1[3*gi+2])) << 1;
        end

        // 8 -> 6: two compressors, two rows pass through
        for (genvar gi = 0; gi < 2; gi++) begin : g_lvl3
            assign l3[2*gi]   = l2[3*gi] ^ l2[3*gi+1] ^ l2[3*gi+2];
            assign l3[2*gi+1] = ((l2[3*gi] & l2[3*gi+1]) | (l2[3*gi] & l2[3*gi+2])
                               | (l2[3*gi+1] & l2[3*gi+2])) << 1;
        end

        // 6 -> 4
        for (genvar gi = 0; gi < 2; gi++) begin : g_lvl4
            assign l4[2*gi]   = l3[3*gi] ^ l3[3*gi+1] ^ l3[3*gi+2];
            assign l4[2*gi+1] = ((l3[3*gi] & l3[3*gi+1]) | (l3[3*gi] & l3[3*gi+2])
                               | (l3[3*gi+1] & l3[3*gi+2])) << 1;
        end
    endgenerate

    assign l3[4] = l2[6];
    assign l3[5] = l2[7];

    // 4 -> 3: one compressor, one row passes through
    assign l5[0] = l4[0] ^ l4[1] ^ l4[2];
    assign l5[1] = ((l4[0] & l4[1]) | (l4[0] & l4[2]) | (l4[1] & l4[2])) << 1;
    assign l5[2] = l4[3];

    // 3 -> 2
    assign l6[0] = l5[0] ^ l5[1] ^ l5[2];
    assign l6[1] = ((l5[0] & l5[1]) | (l5[0] & l5[2]) | (l5[1] & l5[2])) << 1;

    assign sum = l6[0] + l6[1];
endmodule

module wallace_accum_ctrl #(
    parameter int WORDLEN = 16,
    parameter int COUNTW  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORDLEN-1:0] in_data,
    input  logic               in_last,
    output logic               sum_valid,
    input  logic               sum_ready,
    output logic [WORDLEN-1:0] sum_data,
    output logic [COUNTW-1:0]  op_count
);
    localparam int NSLOT = 17;

    typedef enum logic [1:0] {COLLECT, ADD, OUT} state_t;

    state_t               state_q, state_d;
    logic [WORDLEN-1:0]   acc_q, acc_d;
    logic [WORDLEN-1:0]   slot_q [NSLOT];
    logic [WORDLEN-1:0]   slot_d [NSLOT];
    logic [4:0]           idx_q, idx_d;
    logic [COUNTW-1:0]    count_q, count_d;
    logic                 frame_done_q, frame_done_d;

    logic [18*WORDLEN-1:0] adder_in;
    logic [WORDLEN-1:0]    adder_sum;
    logic                  in_xfer;

    // Slots 0..16 feed adder inputs 0..16. The accumulator feeds input 17.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_adder_in
            assign adder_in[gi*WORDLEN +: WORDLEN] = slot_q[gi];
        end
    endgenerate
    assign adder_in[NSLOT*WORDLEN +: WORDLEN] = acc_q;

    Wallace_adder_18 #(.W(WORDLEN)) u_adder (
        .ops_flat (adder_in),
        .sum      (adder_sum)
    );

    // Handshake outputs are pure state decodes.
    // The sum is forced to zero outside OUT so that it never shows a partial accumulator.
    assign in_ready  = (state_q == COLLECT);
    assign sum_valid = (state_q == OUT);
    assign sum_data  = sum_valid ? acc_q : '0;
    assign op_count  = sum_valid ? count_q : '0;
    assign in_xfer   = in_valid && in_ready;

    // Next-state and datapath update for the COLLECT / ADD / OUT sequence
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        slot_d       = slot_q;
        idx_d        = idx_q;
        count_d      = count_q;
        frame_done_d = frame_done_q;
        case (state_q)
            COLLECT: begin
                if (in_xfer) begin
                    slot_d[idx_q] = in_data;
                    idx_d         = idx_q + 5'd1;
                    count_d       = count_q + COUNTW'(1);
                    // A full pass of 17 operands or end of frame triggers an add
                    if (in_last || (idx_q == 5'd16)) begin
                        state_d      = ADD;
                        frame_done_d = in_last;
                    end
                end
            end
            ADD: begin
                acc_d = adder_sum;
                for (int i = 0; i < NSLOT; i++) begin
                    slot_d[i] = '0;
                end
                idx_d   = '0;
                state_d = frame_done_q ? OUT : COLLECT;
            end
            OUT: begin
                if (sum_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State registers. Reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            acc_q        <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end
endmodule
